// File: rtl/pipediv_sched.sv
// pipediv_sched: round-robin front end that shares one pipelined divider
// among NREQ requesters. It tags each operation with its requester id,
// tracks it alongside the divider pipeline and answers divide-by-zero itself.
module pipediv_sched #(
  parameter int DIVIDEND = 8,
  parameter int DIVISOR  = 4,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 8,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIVIDEND-1:0] req_dividend,
  input  logic [NREQ*DIVISOR-1:0]  req_divisor,
  input  logic                     hold,
  output logic [DIVIDEND-1:0]      div_dividend,
  output logic [DIVISOR-1:0]       div_divisor,
  input  logic [DIVIDEND-1:0]      div_quotient,
  input  logic [DIVISOR-1:0]       div_remainder,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [DIVIDEND-1:0]      rsp_quotient,
  output logic [DIVISOR-1:0]       rsp_remainder,
  output logic                     rsp_dbz,
  output logic                     busy
);

  // Arbitration state and the selected request
  logic [IDW-1:0]      last_grant_q, last_grant_d;
  logic                gnt_fire_s;
  logic [IDW-1:0]      gnt_id_s;
  logic [IDW-1:0]      cand_s;
  logic [DIVIDEND-1:0] sel_dividend_s;
  logic [DIVISOR-1:0]  sel_divisor_s;

  // Divider operand registers
  logic [DIVIDEND-1:0] div_dividend_q, div_dividend_d;
  logic [DIVISOR-1:0]  div_divisor_q, div_divisor_d;

  // Tracking pipeline: stage k holds the operation issued k edges ago
  logic                stg_valid_q    [LATENCY+1];
  logic [IDW-1:0]      stg_id_q       [LATENCY+1];
  logic [DIVIDEND-1:0] stg_dividend_q [LATENCY+1];
  logic                stg_dbz_q      [LATENCY+1];

  // Response registers
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [DIVIDEND-1:0] rsp_quotient_q, rsp_quotient_d;
  logic [DIVISOR-1:0]  rsp_remainder_q, rsp_remainder_d;
  logic                rsp_dbz_q, rsp_dbz_d;
  logic                busy_s;

  // Round-robin search starting one past the last grant; idle in reset or hold
  always_comb begin
    gnt_fire_s = 1'b0;
    gnt_id_s   = last_grant_q;
    cand_s     = last_grant_q;
    if (!reset && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand_s = IDW'((int'(last_grant_q) + k) % NREQ);
        if (!gnt_fire_s && req_valid[cand_s]) begin
          gnt_fire_s = 1'b1;
          gnt_id_s   = cand_s;
        end else begin
          gnt_fire_s = gnt_fire_s;
        end
      end
    end else begin
      gnt_fire_s = 1'b0;
    end
    req_ready      = NREQ'(gnt_fire_s) << gnt_id_s;
    sel_dividend_s = req_dividend[int'(gnt_id_s)*DIVIDEND +: DIVIDEND];
    sel_divisor_s  = req_divisor[int'(gnt_id_s)*DIVISOR +: DIVISOR];
  end

  // Next-state for grant pointer and operand registers on a handshake
  always_comb begin
    last_grant_d   = last_grant_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    if (gnt_fire_s) begin
      last_grant_d   = gnt_id_s;
      div_dividend_d = sel_dividend_s;
      div_divisor_d  = sel_divisor_s;
    end else begin
      last_grant_d   = last_grant_q;
    end
  end

  // Response formed from the last tracking stage; fields hold when idle
  always_comb begin
    rsp_valid_d     = stg_valid_q[LATENCY];
    rsp_id_d        = rsp_id_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dbz_d       = rsp_dbz_q;
    if (stg_valid_q[LATENCY]) begin
      rsp_id_d  = stg_id_q[LATENCY];
      rsp_dbz_d = stg_dbz_q[LATENCY];
      if (stg_dbz_q[LATENCY]) begin
        rsp_quotient_d  = '1;
        rsp_remainder_d = stg_dividend_q[LATENCY][DIVISOR-1:0];
      end else begin
        rsp_quotient_d  = div_quotient;
        rsp_remainder_d = div_remainder;
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Registers: grant pointer, operands, tracking shift register, response
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q    <= IDW'(NREQ - 1);
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dbz_q       <= 1'b0;
      for (int s = 0; s <= LATENCY; s++) begin
        stg_valid_q[s]    <= 1'b0;
        stg_id_q[s]       <= '0;
        stg_dividend_q[s] <= '0;
        stg_dbz_q[s]      <= 1'b0;
      end
    end else begin
      last_grant_q      <= last_grant_d;
      div_dividend_q    <= div_dividend_d;
      div_divisor_q     <= div_divisor_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_quotient_q    <= rsp_quotient_d;
      rsp_remainder_q   <= rsp_remainder_d;
      rsp_dbz_q         <= rsp_dbz_d;
      stg_valid_q[0]    <= gnt_fire_s;
      stg_id_q[0]       <= gnt_id_s;
      stg_dividend_q[0] <= sel_dividend_s;
      stg_dbz_q[0]      <= (sel_divisor_s == '0);
      for (int s = 1; s <= LATENCY; s++) begin
        stg_valid_q[s]    <= stg_valid_q[s-1];
        stg_id_q[s]       <= stg_id_q[s-1];
        stg_dividend_q[s] <= stg_dividend_q[s-1];
        stg_dbz_q[s]      <= stg_dbz_q[s-1];
      end
    end
  end

  // Busy while any tracking stage holds an operation
  always_comb begin
    busy_s = 1'b0;
    for (int s = 0; s <= LATENCY; s++) begin
      busy_s = busy_s | stg_valid_q[s];
    end
  end

  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign busy          = busy_s;

endmodule

// File: tb/tb_pipediv_sched.sv
// Scoreboard bench for pipediv_sched with a behavioural pipelined divider.
module tb_pipediv_sched;
  localparam int DD = 8, DS = 4, NR = 4, LAT = 8, IDW = 2;

  logic clock = 1'b0;
  logic reset, hold;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*DD-1:0] req_dividend;
  logic [NR*DS-1:0] req_divisor;
  logic [DD-1:0] div_dividend, div_quotient, rsp_quotient;
  logic [DS-1:0] div_divisor, div_remainder, rsp_remainder;
  logic rsp_valid, rsp_dbz, busy;
  logic [IDW-1:0] rsp_id;

  pipediv_sched #(.DIVIDEND(DD), .DIVISOR(DS), .NREQ(NR), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .hold(hold),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz), .busy(busy));

  always #5 clock = ~clock;

  // Requester state: the presented op is the front of each queue
  logic        rv  [NR];
  logic [7:0]  rdd [NR];
  logic [3:0]  rds [NR];
  logic [11:0] opq [NR][$];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = rv[i];
      req_dividend[i*DD+:DD] = rdd[i];
      req_divisor[i*DS+:DS]  = rds[i];
    end
  end

  // Behavioural divider: LAT-stage pipeline, junk on divide-by-zero
  logic [7:0] pq [LAT];
  logic [3:0] pr [LAT];
  always @(posedge clock) begin
    pq[0] <= (div_divisor == 4'd0) ? 8'h5A : div_dividend / {4'd0, div_divisor};
    pr[0] <= (div_divisor == 4'd0) ? 4'h5 : 4'(div_dividend % {4'd0, div_divisor});
    for (int k = 1; k < LAT; k++) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign div_quotient  = pq[LAT-1];
  assign div_remainder = pr[LAT-1];

  typedef struct { int id; int q; int r; int dbz; int due; } exp_t;
  exp_t sb[$];
  exp_t rlog[$];
  int   glog[$];
  int   tests = 0, fails = 0, nc = 0, nrsp = 0;
  int   last_m, g_m, idx_m;
  logic hs_fire = 1'b0;
  int   hs_id = 0;
  exp_t e_m, a_m;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference arbiter, evaluated between active edges
  initial forever begin
    @(negedge clock);
    nc++;
    if (rsp_valid) begin
      nrsp++;
      a_m.id = int'(rsp_id); a_m.q = int'(rsp_quotient);
      a_m.r = int'(rsp_remainder); a_m.dbz = int'(rsp_dbz); a_m.due = nc;
      rlog.push_back(a_m);
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e_m = sb.pop_front();
        chk("rsp_id", a_m.id, e_m.id);
        chk("rsp_quotient", a_m.q, e_m.q);
        chk("rsp_remainder", a_m.r, e_m.r);
        chk("rsp_dbz", a_m.dbz, e_m.dbz);
        chk("rsp_latency", nc, e_m.due);
      end
    end
    if (reset) begin
      sb.delete();
      last_m  = NR - 1;
      hs_fire = 1'b0;
      chk("ready_in_reset", int'(req_ready), 0);
    end else begin
      g_m = -1;
      if (!hold) begin
        for (int k = 1; k <= NR; k++) begin
          idx_m = (last_m + k) % NR;
          if (g_m < 0 && rv[idx_m]) g_m = idx_m;
        end
      end
      chk("req_ready", int'(req_ready), (g_m >= 0) ? (1 << g_m) : 0);
      if (g_m >= 0) begin
        e_m.id  = g_m;
        e_m.dbz = (rds[g_m] == 4'd0) ? 1 : 0;
        e_m.q   = e_m.dbz ? 255 : int'(rdd[g_m]) / int'(rds[g_m]);
        e_m.r   = e_m.dbz ? int'(rdd[g_m][3:0]) : int'(rdd[g_m]) % int'(rds[g_m]);
        e_m.due = nc + LAT + 2;
        sb.push_back(e_m);
        glog.push_back(g_m);
        last_m  = g_m;
        hs_fire = 1'b1;
        hs_id   = g_m;
      end else hs_fire = 1'b0;
    end
  end

  // Feeder: retire the granted op, present the next queued op per requester
  initial forever begin
    @(posedge clock);
    #1;
    if (hs_fire) void'(opq[hs_id].pop_front());
    for (int i = 0; i < NR; i++) begin
      if (opq[i].size() > 0) begin
        {rdd[i], rds[i]} = opq[i][0];
        rv[i] = 1'b1;
      end else rv[i] = 1'b0;
    end
  end

  function automatic int pending();
    int n;
    n = sb.size();
    for (int i = 0; i < NR; i++) n += opq[i].size();
    return n;
  endfunction

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((pending() != 0 || busy) && c < maxc) begin
      @(negedge clock);
      c++;
    end
    chk("drain_outstanding", pending(), 0);
    @(negedge clock);
  endtask

  task automatic wait_grants(input int target);
    int c;
    c = 0;
    while (glog.size() < target && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("grant_wait", glog.size(), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_quotient"}, int'(rsp_quotient), 0);
    chk({tag, "_rsp_remainder"}, int'(rsp_remainder), 0);
    chk({tag, "_rsp_dbz"}, int'(rsp_dbz), 0);
    chk({tag, "_div_dividend"}, int'(div_dividend), 0);
    chk({tag, "_div_divisor"}, int'(div_divisor), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int b, r0, k;
  initial begin
    reset = 1'b1; hold = 1'b0;
    for (int i = 0; i < NR; i++) begin rv[i] = 1'b0; rdd[i] = 8'd0; rds[i] = 4'd0; end
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #2 reset = 1'b0;

    // All four continuously valid from reset: grants 0,1,2,3,0,1,...
    b = glog.size();
    for (int rep = 0; rep < 3; rep++)
      for (int i = 0; i < NR; i++)
        opq[i].push_back({8'(17 * (rep * 4 + i) + 5), 4'(i + rep + 1)});
    drain(200);
    for (int j = 0; j < 8; j++) chk("rr_order", glog[b + j], j % 4);

    // Single request: 200/7 from requester 2 -> id 2, q 28, r 4
    r0 = nrsp;
    opq[2].push_back({8'd200, 4'd7});
    drain(100);
    chk("single_count", nrsp - r0, 1);
    chk("single_id", rlog[r0].id, 2);
    chk("single_q", rlog[r0].q, 28);
    chk("single_r", rlog[r0].r, 4);
    chk("single_dbz", rlog[r0].dbz, 0);
    chk("single_latency_idle", int'(busy), 0);

    // Divide by zero among neighbours: 10/3, 45/0, 100/9
    r0 = nrsp;
    opq[0].push_back({8'd10, 4'd3});
    opq[1].push_back({8'd45, 4'd0});
    opq[2].push_back({8'd100, 4'd9});
    drain(100);
    chk("dbz_count", nrsp - r0, 3);
    chk("dbz_id", rlog[r0 + 1].id, 1);
    chk("dbz_q", rlog[r0 + 1].q, 255);
    chk("dbz_r", rlog[r0 + 1].r, 13);
    chk("dbz_flag", rlog[r0 + 1].dbz, 1);
    chk("dbz_next_q", rlog[r0 + 2].q, 11);
    chk("dbz_next_r", rlog[r0 + 2].r, 1);

    // hold with 3 in flight (3,0,1) and 2 pending (2,0)
    b = glog.size();
    opq[0].push_back({8'd99, 4'd5});
    opq[0].push_back({8'd250, 4'd15});
    opq[1].push_back({8'd7, 4'd2});
    opq[2].push_back({8'd64, 4'd8});
    opq[3].push_back({8'd130, 4'd11});
    wait_grants(b + 3);
    @(posedge clock); #2 hold = 1'b1;
    r0 = nrsp;
    repeat (14) @(negedge clock);
    chk("hold_rsp_count", nrsp - r0, 3);
    chk("hold_no_grant", glog.size(), b + 3);
    chk("hold_busy_low", int'(busy), 0);
    @(posedge clock); #2 hold = 1'b0;
    drain(100);
    chk("hold_first3", glog[b], 3);
    chk("hold_resume_a", glog[b + 3], 2);
    chk("hold_resume_b", glog[b + 4], 0);

    // Exhaustive operand sweep over rotating requesters
    r0 = nrsp;
    k = 0;
    for (int ds = 0; ds < 16; ds++)
      for (int dd = 0; dd < 256; dd++) begin
        opq[k % NR].push_back({8'(dd), 4'(ds)});
        k++;
      end
    drain(6000);
    chk("exhaustive_count", nrsp - r0, 4096);

    // Reset pulse with five operations in flight
    b = glog.size();
    opq[0].push_back({8'd11, 4'd2});
    opq[0].push_back({8'd12, 4'd3});
    opq[1].push_back({8'd13, 4'd4});
    opq[2].push_back({8'd14, 4'd5});
    opq[3].push_back({8'd15, 4'd6});
    wait_grants(b + 5);
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    r0 = nrsp;
    repeat (15) @(negedge clock);
    chk("midreset_no_rsp", nrsp - r0, 0);
    b = glog.size();
    opq[2].push_back({8'd77, 4'd7});
    opq[0].push_back({8'd50, 4'd6});
    drain(100);
    chk("midreset_first_grant", glog[b], 0);
    chk("midreset_second_grant", glog[b + 1], 2);
    chk("midreset_rsp_count", nrsp - r0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipediv_sched.md
# pipediv_sched

Round-robin scheduler that shares one external `pipelinediv` instance among NREQ requesters. Each cycle it grants at most one pending request, drives the divider operands, and tracks the requester tag and dividend alongside the divider pipeline. It returns each result on a shared response bus tagged with the requester id, and handles divide-by-zero itself. It sits between the requesting units and the divider; the divider stays purely a datapath.

## Interface
- DIVIDEND, 8, dividend and quotient width.
- DIVISOR, 4, divisor and remainder width.
- NREQ, 4, number of requesters (2..8).
- LATENCY, 8, edges from operands presented at `div_*` to the result valid at `div_quotient`/`div_remainder` (0 = combinational divider).
- IDW, $clog2(NREQ), width of the requester id.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  grant; at most one bit high.
- req_dividend  in  NREQ*DIVIDEND  packed operands; requester i at [i*DIVIDEND +: DIVIDEND].
- req_divisor  in  NREQ*DIVISOR  packed; requester i at [i*DIVISOR +: DIVISOR].
- hold  in  1  suppress new grants; in-flight work drains.
- div_dividend  out  DIVIDEND  registered operand to the divider.
- div_divisor  out  DIVISOR  registered operand to the divider.
- div_quotient  in  DIVIDEND  divider result.
- div_remainder  in  DIVISOR  divider result.
- rsp_valid  out  1  response strobe, one cycle, no backpressure.
- rsp_id  out  IDW  requester index of the response.
- rsp_quotient  out  DIVIDEND  quotient.
- rsp_remainder  out  DIVISOR  remainder.
- rsp_dbz  out  1  divisor was zero.
- busy  out  1  any operation in flight.

## Operation
- Arbitration:
  - Round-robin over req_valid. Priority starts at (last_grant+1) mod NREQ.
  - req_ready is combinational from req_valid, last_grant and hold. It is all-zero when hold=1 or no request is pending.
  - Handshake = req_valid[i] & req_ready[i] at a rising edge. On handshake, last_grant<=i and operands are registered into div_dividend/div_divisor.
  - A requester keeps valid and operands stable until granted. Dropping valid before the grant withdraws the request; this is legal.
- In-flight tracking:
  - A shift register of depth LATENCY+1 carries {valid, id, dividend, dbz} per stage.
  - Every cycle it shifts; the stage entering is the handshake (valid=0 on no handshake).
  - The divider never stalls, so one issue per cycle is sustainable indefinitely.
- Response, registered on the edge where the tracking stage aligns with the divider output:
  - rsp_valid=stage valid, rsp_id=stage id.
  - Normal case: rsp_quotient=div_quotient and rsp_remainder=div_remainder.
  - dbz=1: rsp_quotient=all ones, rsp_remainder=dividend[DIVISOR-1:0], rsp_dbz=1. The divider output is ignored.
  - When rsp_valid=0, rsp_quotient, rsp_remainder, rsp_id and rsp_dbz hold their previous values.
- busy = OR of all tracking-stage valid bits (combinational).
- Arithmetic: unsigned only. remainder < divisor whenever divisor != 0.

## Timing
- Reset values, all registered:
  - div_dividend=0, div_divisor=0.
  - rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_dbz=0.
  - Tracking stages cleared; busy=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: all in-flight work is discarded with no response. Responses resume only for requests handshaken after reset deasserts. req_ready=0 while reset=1.
- Latency: handshake at edge E0 gives rsp_valid high for exactly the cycle after edge E0+LATENCY+1.
- Throughput: one response per cycle. Responses come back in issue order.
- hold:
  - hold asserted in the same cycle as a pending request → no grant that cycle.
  - hold does not affect in-flight stages.
  - With hold held high, busy falls LATENCY+1 edges after the last issue.
- Simultaneous requests: exactly one grant. A requester with continuous valid waits at most NREQ-1 grants.
- Wrap-around: when last_grant=NREQ-1, the search restarts at 0.

## Test plan
- Single request, NREQ=4, LATENCY=8: requester 2 issues 200/7 at E0 → rsp_valid once after E9, rsp_id=2, quotient 28, remainder 4, dbz=0.
- All four requesters valid continuously after reset → grants in order 0,1,2,3,0,1…; each granted once per 4 cycles; responses return in the same order, back to back.
- Divide by zero: 45/0 from requester 1 → rsp_dbz=1, quotient 255, remainder 45[3:0]=13; no other response is disturbed.
- Exhaustive: every {divisor, dividend} combination, issued back-to-back from rotating requesters → each response matches dividend/divisor and dividend%divisor, with the correct id.
- hold asserted with 3 requests in flight and 2 pending → req_ready=0 throughout; exactly 3 responses; busy falls after the last one; after release, pending grants resume round-robin.
- reset pulsed for one cycle with 5 ops in flight → no rsp_valid for them; all outputs at reset values; next grant goes to requester 0.
